// File: rtl/qea_pkg.sv
// Shared definitions for the QEA host sequencer: FSM encoding and fixed-point unit value.
// No logic; no latency; no backpressure.
// Pure declarations imported by the sequencer.
package qea_pkg;

    typedef enum logic [3:0] {
        S_IDLE       = 4'd0,
        S_LOAD_CTX   = 4'd1,
        S_INIT_STATE = 4'd2,
        S_START      = 4'd3,
        S_RUN        = 4'd4,
        S_RD_ADDR    = 4'd5,
        S_RD_WAIT    = 4'd6,
        S_RD_OUT     = 4'd7,
        S_DONE       = 4'd8
    } qea_state_t;

    // Fixed-point 1.0 for a given number of fraction bits; callers slice to their data width.
    function automatic logic [63:0] qea_one(input int unsigned frac_bits);
        return 64'd1 << frac_bits;
    endfunction

endpackage

// File: rtl/qea_rd_hold_reg.sv
// Readback output register: holds one state row until the consumer accepts it.
// Latency: data visible the cycle after i_load.
// Backpressure: o_valid/o_data/o_last stay frozen until i_pop (valid & ready).
module qea_rd_hold_reg #(
    parameter int WIDTH = 256
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_load,
    input  logic             i_pop,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_last,
    output logic             o_valid,
    output logic [WIDTH-1:0] o_data,
    output logic             o_last
);

    always_ff @(posedge clk) begin
        if (rst) begin
            o_valid <= 1'b0;
            o_data  <= '0;
            o_last  <= 1'b0;
        end else if (i_load) begin
            o_valid <= 1'b1;
            o_data  <= i_data;
            o_last  <= i_last;
        end else if (i_pop) begin
            o_valid <= 1'b0;
            o_last  <= 1'b0;
        end
    end

endmodule

// File: rtl/qea_host_seq.sv
// Host sequencer for the QEA: loads gate context, initialises state RAM, runs the engine, streams state back.
// Latency: all outputs registered (one cycle after the deciding input); readback row 3 cycles after address issue.
// Backpressure: ctx stream stalls on i_ctx_valid low; readback holds each row until i_rd_ready.
module qea_host_seq
    import qea_pkg::*;
#(
    parameter int PE_NUM_WIDTH            = 2,
    parameter int PE_NUM                  = 4,
    parameter int DATA_WIDTH              = 32,
    parameter int STATE_ADDR_WIDTH        = 16,
    parameter int GATE_CONTEXT_ADDR_WIDTH = 16,
    parameter int MAX_QBIT_WIDTH          = 6,
    parameter int NUM_FRAC_BIT            = 30,
    parameter int TIMEOUT_WIDTH           = 32
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 i_go,
    input  logic [MAX_QBIT_WIDTH-1:0]            i_qbit_num,
    input  logic [GATE_CONTEXT_ADDR_WIDTH:0]     i_ins_num,
    input  logic [TIMEOUT_WIDTH-1:0]             i_timeout,
    input  logic                                 i_ctx_valid,
    output logic                                 o_ctx_ready,
    input  logic [2*DATA_WIDTH-1:0]              i_ctx_data,
    output logic                                 o_qea_ctx_en,
    output logic                                 o_qea_ctx_wea,
    output logic [GATE_CONTEXT_ADDR_WIDTH-1:0]   o_qea_ctx_addr,
    output logic [2*DATA_WIDTH-1:0]              o_qea_ctx_data,
    output logic                                 o_qea_state_ena,
    output logic                                 o_qea_state_wea,
    output logic [STATE_ADDR_WIDTH-1:0]          o_qea_state_addra,
    output logic [PE_NUM*2*DATA_WIDTH-1:0]       o_qea_state_dina,
    output logic                                 o_qea_start,
    output logic [MAX_QBIT_WIDTH-1:0]            o_qea_qbit_num,
    input  logic                                 i_qea_complete,
    input  logic [PE_NUM*2*DATA_WIDTH-1:0]       i_qea_state_dout,
    output logic                                 o_rd_valid,
    input  logic                                 i_rd_ready,
    output logic [PE_NUM*2*DATA_WIDTH-1:0]       o_rd_data,
    output logic                                 o_rd_last,
    output logic                                 o_busy,
    output logic                                 o_done,
    output logic                                 o_timeout,
    output logic                                 o_cfg_err,
    output logic [TIMEOUT_WIDTH-1:0]             o_cycle_count
);

    localparam int ROW_W = PE_NUM * 2 * DATA_WIDTH;
    localparam int RCW   = STATE_ADDR_WIDTH + 1;
    localparam int ICW   = GATE_CONTEXT_ADDR_WIDTH + 1;

    localparam logic [MAX_QBIT_WIDTH-1:0] L_QMIN    = MAX_QBIT_WIDTH'(PE_NUM_WIDTH);
    localparam logic [MAX_QBIT_WIDTH-1:0] L_QMAX    = MAX_QBIT_WIDTH'(STATE_ADDR_WIDTH + PE_NUM_WIDTH);
    localparam logic [ICW-1:0]            L_MAX_INS = ICW'(1) << GATE_CONTEXT_ADDR_WIDTH;
    localparam logic [63:0]               L_ONE_W   = qea_one(NUM_FRAC_BIT);
    localparam logic [DATA_WIDTH-1:0]     L_ONE     = L_ONE_W[DATA_WIDTH-1:0];
    // PE0 occupies the low 2*DATA_WIDTH bits with its real part on top: |0> amplitude = 1.0.
    localparam logic [ROW_W-1:0]          L_ROW0    = {{(ROW_W-2*DATA_WIDTH){1'b0}}, L_ONE, {DATA_WIDTH{1'b0}}};

    qea_state_t                r_state;
    logic [ICW-1:0]            r_ins_num;
    logic [ICW-1:0]            r_ctx_cnt;
    logic [RCW-1:0]            r_rows;
    logic [RCW-1:0]            r_row;

    logic                      w_cfg_bad;
    logic [RCW-1:0]            w_rows_go;
    logic                      w_ctx_last;
    logic                      w_row_last;
    logic [TIMEOUT_WIDTH-1:0]  w_cnt_next;
    logic                      w_timeout_hit;
    logic                      w_rd_load;
    logic                      w_rd_pop;

    assign w_cfg_bad     = (i_qbit_num < L_QMIN) || (i_qbit_num > L_QMAX) || (i_ins_num > L_MAX_INS);
    assign w_rows_go     = RCW'(1) << (i_qbit_num - L_QMIN);
    assign w_ctx_last    = (r_ctx_cnt == r_ins_num - ICW'(1));
    assign w_row_last    = (r_row == r_rows - RCW'(1));
    assign w_cnt_next    = (&o_cycle_count) ? o_cycle_count : o_cycle_count + TIMEOUT_WIDTH'(1);
    assign w_timeout_hit = (i_timeout != '0) && (w_cnt_next >= i_timeout);
    // First RD_OUT cycle loads the row; later RD_OUT cycles wait for the consumer.
    assign w_rd_load     = (r_state == S_RD_OUT) && !o_rd_valid;
    assign w_rd_pop      = (r_state == S_RD_OUT) && o_rd_valid && i_rd_ready;

    qea_rd_hold_reg #(
        .WIDTH (ROW_W)
    ) u_rd_hold (
        .clk     (clk),
        .rst     (rst),
        .i_load  (w_rd_load),
        .i_pop   (w_rd_pop),
        .i_data  (i_qea_state_dout),
        .i_last  (w_row_last),
        .o_valid (o_rd_valid),
        .o_data  (o_rd_data),
        .o_last  (o_rd_last)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state           <= S_IDLE;
            r_ins_num         <= '0;
            r_ctx_cnt         <= '0;
            r_rows            <= '0;
            r_row             <= '0;
            o_ctx_ready       <= 1'b0;
            o_qea_ctx_en      <= 1'b0;
            o_qea_ctx_wea     <= 1'b0;
            o_qea_ctx_addr    <= '0;
            o_qea_ctx_data    <= '0;
            o_qea_state_ena   <= 1'b0;
            o_qea_state_wea   <= 1'b0;
            o_qea_state_addra <= '0;
            o_qea_state_dina  <= '0;
            o_qea_start       <= 1'b0;
            o_qea_qbit_num    <= '0;
            o_busy            <= 1'b0;
            o_done            <= 1'b0;
            o_timeout         <= 1'b0;
            o_cfg_err         <= 1'b0;
            o_cycle_count     <= '0;
        end else begin
            o_qea_ctx_en    <= 1'b0;
            o_qea_ctx_wea   <= 1'b0;
            o_qea_state_ena <= 1'b0;
            o_qea_state_wea <= 1'b0;
            o_qea_start     <= 1'b0;
            o_done          <= 1'b0;

            case (r_state)
                S_IDLE: begin
                    if (i_go) begin
                        if (w_cfg_bad) begin
                            o_cfg_err <= 1'b1;
                        end else begin
                            o_cfg_err      <= 1'b0;
                            o_timeout      <= 1'b0;
                            o_busy         <= 1'b1;
                            o_qea_qbit_num <= i_qbit_num;
                            r_ins_num      <= i_ins_num;
                            r_rows         <= w_rows_go;
                            r_ctx_cnt      <= '0;
                            r_row          <= '0;
                            if (i_ins_num == '0) begin
                                r_state <= S_INIT_STATE;
                            end else begin
                                o_ctx_ready <= 1'b1;
                                r_state     <= S_LOAD_CTX;
                            end
                        end
                    end
                end

                S_LOAD_CTX: begin
                    if (i_ctx_valid && o_ctx_ready) begin
                        o_qea_ctx_en   <= 1'b1;
                        o_qea_ctx_wea  <= 1'b1;
                        o_qea_ctx_addr <= r_ctx_cnt[GATE_CONTEXT_ADDR_WIDTH-1:0];
                        o_qea_ctx_data <= i_ctx_data;
                        r_ctx_cnt      <= r_ctx_cnt + ICW'(1);
                        // Dropping ready on the same edge guarantees no extra word is taken.
                        if (w_ctx_last) begin
                            o_ctx_ready <= 1'b0;
                            r_state     <= S_INIT_STATE;
                        end
                    end
                end

                S_INIT_STATE: begin
                    o_qea_state_ena   <= 1'b1;
                    o_qea_state_wea   <= 1'b1;
                    o_qea_state_addra <= r_row[STATE_ADDR_WIDTH-1:0];
                    o_qea_state_dina  <= (r_row == '0) ? L_ROW0 : '0;
                    if (w_row_last) begin
                        r_row   <= '0;
                        r_state <= S_START;
                    end else begin
                        r_row <= r_row + RCW'(1);
                    end
                end

                S_START: begin
                    o_qea_start   <= 1'b1;
                    o_cycle_count <= '0;
                    r_state       <= S_RUN;
                end

                S_RUN: begin
                    if (i_qea_complete) begin
                        r_row   <= '0;
                        r_state <= S_RD_ADDR;
                    end else begin
                        o_cycle_count <= w_cnt_next;
                        if (w_timeout_hit) begin
                            o_timeout <= 1'b1;
                            o_done    <= 1'b1;
                            r_state   <= S_DONE;
                        end
                    end
                end

                S_RD_ADDR: begin
                    o_qea_state_ena   <= 1'b1;
                    o_qea_state_wea   <= 1'b0;
                    o_qea_state_addra <= r_row[STATE_ADDR_WIDTH-1:0];
                    r_state           <= S_RD_WAIT;
                end

                S_RD_WAIT: begin
                    r_state <= S_RD_OUT;
                end

                S_RD_OUT: begin
                    if (w_rd_pop) begin
                        if (o_rd_last) begin
                            o_done  <= 1'b1;
                            r_state <= S_DONE;
                        end else begin
                            r_row   <= r_row + RCW'(1);
                            r_state <= S_RD_ADDR;
                        end
                    end
                end

                S_DONE: begin
                    o_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end

                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule
